// File: rtl/sched_pkg.sv
// Shared types and sizes for the dual-issue scheduler.
//   dec_inst_t    : packed decoded-instruction bundle (DEC_W bits)
//   sched_state_t : occupancy of the held pair {EMPTY, PAIR, SINGLE}
//   NREG / REG_W  : scoreboard depth and register index width
package sched_pkg;

  localparam int unsigned DEC_W = 30;
  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             rs2_en;
    logic [3:0]       alu_opr;
    logic             reg_write_en;
    logic             mem_write_en;
    logic             mem_read_en;
    logic             branch_en;
    logic [2:0]       load_flag;
    logic [1:0]       store_flag;
  } dec_inst_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PAIR   = 2'd1,
    SINGLE = 2'd2
  } sched_state_t;

  // True when the bundle produces an architectural result (x0 writes are void).
  function automatic logic writes_reg(input dec_inst_t i);
    return i.reg_write_en && (i.rd != '0);
  endfunction

  // True when the bundle needs the shared memory port.
  function automatic logic is_mem(input dec_inst_t i);
    return i.mem_read_en || i.mem_write_en;
  endfunction

endpackage

// File: rtl/sched_scoreboard.sv
// Register busy scoreboard for the dual-issue scheduler.
//   clk, rst_n            : clock, synchronous active-low reset
//   set0_*/set1_*         : mark a destination busy (issue of lane 0 / lane 1)
//   clr0_*/clr1_*         : clear a destination (writeback ports)
//   a_*/b_*               : register indices of held slots A and B
//   a_*_busy_c/b_*_busy_c : combinational busy lookups for those indices
module sched_scoreboard
  import sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set0_en,
  input  logic [REG_W-1:0] set0_rd,
  input  logic             set1_en,
  input  logic [REG_W-1:0] set1_rd,
  input  logic             clr0_en,
  input  logic [REG_W-1:0] clr0_rd,
  input  logic             clr1_en,
  input  logic [REG_W-1:0] clr1_rd,
  input  logic [REG_W-1:0] a_rs1,
  input  logic [REG_W-1:0] a_rs2,
  input  logic [REG_W-1:0] a_rd,
  input  logic [REG_W-1:0] b_rs1,
  input  logic [REG_W-1:0] b_rs2,
  input  logic [REG_W-1:0] b_rd,
  output logic             a_rs1_busy_c,
  output logic             a_rs2_busy_c,
  output logic             a_rd_busy_c,
  output logic             b_rs1_busy_c,
  output logic             b_rs2_busy_c,
  output logic             b_rd_busy_c
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Clears apply first so a same-cycle set of the same register wins; x0 never busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set0_en) set_mask = set_mask | (NREG'(1) << set0_rd);
    if (set1_en) set_mask = set_mask | (NREG'(1) << set1_rd);
    if (clr0_en) clr_mask = clr_mask | (NREG'(1) << clr0_rd);
    if (clr1_en) clr_mask = clr_mask | (NREG'(1) << clr1_rd);
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~NREG'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Lookups see the registered vector only: no writeback bypass.
  assign a_rs1_busy_c = busy_q[a_rs1];
  assign a_rs2_busy_c = busy_q[a_rs2];
  assign a_rd_busy_c  = busy_q[a_rd];
  assign b_rs1_busy_c = busy_q[b_rs1];
  assign b_rs2_busy_c = busy_q[b_rs2];
  assign b_rd_busy_c  = busy_q[b_rd];

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: holds one decoded pair (slot A older, slot B younger)
// and issues zero, one or both per cycle, splitting the pair when only A can go.
//   clk, rst_n             : clock, synchronous active-low reset
//   in0/in1, in_valid      : incoming pair (in0 older); in_ready accepts it
//   flush                  : drop held instructions, block issue and accept
//   wb0_*/wb1_*            : writeback ports clearing scoreboard bits
//   iss0/iss1, iss*_valid  : issued bundles, lane 0 from A, lane 1 from B
// Optional (macro SCHED_PERF_EN): perf_dual, perf_single, perf_stall
// saturating 32-bit event counters.
module dual_issue_scheduler
  import sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEC_W-1:0] in0,
  input  logic [DEC_W-1:0] in1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             wb0_en,
  input  logic             wb1_en,
  input  logic [REG_W-1:0] wb0_rd,
  input  logic [REG_W-1:0] wb1_rd,
  output logic [DEC_W-1:0] iss0,
  output logic [DEC_W-1:0] iss1,
  output logic             iss0_valid,
  output logic             iss1_valid
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]      perf_dual,
  output logic [31:0]      perf_single,
  output logic [31:0]      perf_stall
`endif
);

  sched_state_t state_q, state_d;
  dec_inst_t    a_q, a_d, b_q, b_d;
  dec_inst_t    in0_i, in1_i;

  logic a_rs1_busy, a_rs2_busy, a_rd_busy;
  logic b_rs1_busy, b_rs2_busy, b_rd_busy;
  logic a_sb_ok, b_sb_ok, b_raw, b_waw, b_mem;
  logic a_go, b_go, accept;

  assign in0_i = dec_inst_t'(in0);
  assign in1_i = dec_inst_t'(in1);

  sched_scoreboard u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .set0_en      (a_go && writes_reg(a_q)),
    .set0_rd      (a_q.rd),
    .set1_en      (b_go && writes_reg(b_q)),
    .set1_rd      (b_q.rd),
    .clr0_en      (wb0_en),
    .clr0_rd      (wb0_rd),
    .clr1_en      (wb1_en),
    .clr1_rd      (wb1_rd),
    .a_rs1        (a_q.rs1),
    .a_rs2        (a_q.rs2),
    .a_rd         (a_q.rd),
    .b_rs1        (b_q.rs1),
    .b_rs2        (b_q.rs2),
    .b_rd         (b_q.rd),
    .a_rs1_busy_c (a_rs1_busy),
    .a_rs2_busy_c (a_rs2_busy),
    .a_rd_busy_c  (a_rd_busy),
    .b_rs1_busy_c (b_rs1_busy),
    .b_rs2_busy_c (b_rs2_busy),
    .b_rd_busy_c  (b_rd_busy)
  );

  // Scoreboard readiness of each slot: sources plus WAW on its own destination.
  assign a_sb_ok = !a_rs1_busy && !(a_q.rs2_en && a_rs2_busy) && !(writes_reg(a_q) && a_rd_busy);
  assign b_sb_ok = !b_rs1_busy && !(b_q.rs2_en && b_rs2_busy) && !(writes_reg(b_q) && b_rd_busy);

  // Intra-pair hazards that force B to wait behind A.
  assign b_raw = writes_reg(a_q) && ((a_q.rd == b_q.rs1) || (b_q.rs2_en && (a_q.rd == b_q.rs2)));
  assign b_waw = writes_reg(a_q) && writes_reg(b_q) && (a_q.rd == b_q.rd);
  assign b_mem = is_mem(a_q) && is_mem(b_q);

  assign a_go = rst_n && !flush && (state_q != EMPTY) && a_sb_ok;
  assign b_go = a_go && (state_q == PAIR) && b_sb_ok && !b_raw && !b_waw && !b_mem && !a_q.branch_en;

  assign in_ready = rst_n && !flush &&
                    ((state_q == EMPTY) || (a_go && ((state_q == SINGLE) || b_go)));
  assign accept   = in_valid && in_ready;

  assign iss0_valid = a_go;
  assign iss1_valid = b_go;
  assign iss0       = a_go ? a_q : '0;
  assign iss1       = b_go ? b_q : '0;

  // Next-state: flush, then new pair, then split/drain of the held pair.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      if (in0_i.valid) begin
        a_d     = in0_i;
        b_d     = in1_i;
        state_d = in1_i.valid ? PAIR : SINGLE;
      end else if (in1_i.valid) begin
        a_d     = in1_i;
        state_d = SINGLE;
      end else begin
        state_d = EMPTY;
      end
    end else if (a_go) begin
      if ((state_q == PAIR) && !b_go) begin
        a_d     = b_q;
        state_d = SINGLE;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

`ifdef SCHED_PERF_EN
  // Saturating issue/stall event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_dual   <= '0;
      perf_single <= '0;
      perf_stall  <= '0;
    end else begin
      if (a_go && b_go && (perf_dual != '1))
        perf_dual <= perf_dual + 32'd1;
      if (a_go && !b_go && (perf_single != '1))
        perf_single <= perf_single + 32'd1;
      if ((state_q != EMPTY) && !a_go && !flush && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: per-cycle vector table plus
// reset and (with SCHED_PERF_EN) counter sequences.
module tb_dual_issue_scheduler;
  import sched_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DEC_W-1:0] in0, in1;
  logic             in_valid, in_ready, flush;
  logic             wb0_en, wb1_en;
  logic [REG_W-1:0] wb0_rd, wb1_rd;
  logic [DEC_W-1:0] iss0, iss1;
  logic             iss0_valid, iss1_valid;
`ifdef SCHED_PERF_EN
  logic [31:0]      perf_dual, perf_single, perf_stall;
`endif

  always #5 clk = ~clk;

  dual_issue_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in0        (in0),
    .in1        (in1),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .wb0_en     (wb0_en),
    .wb1_en     (wb1_en),
    .wb0_rd     (wb0_rd),
    .wb1_rd     (wb1_rd),
    .iss0       (iss0),
    .iss1       (iss1),
    .iss0_valid (iss0_valid),
    .iss1_valid (iss1_valid)
`ifdef SCHED_PERF_EN
    ,
    .perf_dual   (perf_dual),
    .perf_single (perf_single),
    .perf_stall  (perf_stall)
`endif
  );

  typedef struct {
    dec_inst_t        i0, i1;
    logic             iv, fl, w0e, w1e;
    logic [REG_W-1:0] w0r, w1r;
    logic             rdy, ev0, ev1;
    dec_inst_t        e0, e1;
    logic [31:0]      eb;
  } vec_t;

  localparam int NV = 24;
  vec_t vt[NV];

  int n_tests = 0;
  int n_fail  = 0;

  dec_inst_t Z, ADD1, ADD4, SUB7, LD9, SD10, BEQ, ADD15, ADD5, ADD1B;
  dec_inst_t NW0, NW1, W20, R21;

  function automatic dec_inst_t mk(input logic [4:0] rd, rs1, rs2,
                                   input logic rs2_en, rwe, mr, mw, br);
    dec_inst_t i;
    i              = '0;
    i.valid        = 1'b1;
    i.rd           = rd;
    i.rs1          = rs1;
    i.rs2          = rs2;
    i.rs2_en       = rs2_en;
    i.alu_opr      = 4'h1;
    i.reg_write_en = rwe;
    i.mem_read_en  = mr;
    i.mem_write_en = mw;
    i.branch_en    = br;
    i.load_flag    = mr ? 3'd3 : 3'd0;
    i.store_flag   = mw ? 2'd3 : 2'd0;
    return i;
  endfunction

  function automatic vec_t mkv(input dec_inst_t i0, i1, input logic iv, fl,
                               input logic w0e, input logic [4:0] w0r,
                               input logic w1e, input logic [4:0] w1r,
                               input logic rdy, ev0, ev1,
                               input dec_inst_t e0, e1, input logic [31:0] eb);
    vec_t v;
    v.i0 = i0; v.i1 = i1; v.iv = iv; v.fl = fl;
    v.w0e = w0e; v.w0r = w0r; v.w1e = w1e; v.w1r = w1r;
    v.rdy = rdy; v.ev0 = ev0; v.ev1 = ev1; v.e0 = e0; v.e1 = e1; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input dec_inst_t i0, i1, input logic iv, fl,
                       input logic w0e, input logic [4:0] w0r,
                       input logic w1e, input logic [4:0] w1r);
    in0 = i0; in1 = i1; in_valid = iv; flush = fl;
    wb0_en = w0e; wb0_rd = w0r; wb1_en = w1e; wb1_rd = w1r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    Z     = '0;
    ADD1  = mk(5'd1,  5'd2,  5'd3,  1, 1, 0, 0, 0);
    ADD4  = mk(5'd4,  5'd5,  5'd6,  1, 1, 0, 0, 0);
    SUB7  = mk(5'd7,  5'd1,  5'd8,  1, 1, 0, 0, 0);
    LD9   = mk(5'd9,  5'd11, 5'd0,  0, 1, 1, 0, 0);
    SD10  = mk(5'd0,  5'd12, 5'd10, 1, 0, 0, 1, 0);
    BEQ   = mk(5'd0,  5'd13, 5'd14, 1, 0, 0, 0, 1);
    ADD15 = mk(5'd15, 5'd16, 5'd17, 1, 1, 0, 0, 0);
    ADD5  = mk(5'd5,  5'd2,  5'd3,  1, 1, 0, 0, 0);
    ADD1B = mk(5'd1,  5'd5,  5'd6,  1, 1, 0, 0, 0);
    NW0   = mk(5'd0,  5'd2,  5'd3,  1, 0, 0, 0, 0);
    NW1   = mk(5'd0,  5'd4,  5'd5,  1, 0, 0, 0, 0);
    W20   = mk(5'd20, 5'd2,  5'd3,  1, 1, 0, 0, 0);
    R21   = mk(5'd21, 5'd20, 5'd2,  1, 1, 0, 0, 0);

    //           i0    i1     iv fl w0e w0r w1e w1r rdy v0 v1 e0     e1    busy
    vt[0]  = mkv(ADD1, ADD4,  1, 0, 0, 0,  0, 0,  1, 0, 0, Z,     Z,    32'h0);
    vt[1]  = mkv(Z,    Z,     0, 0, 0, 0,  0, 0,  1, 1, 1, ADD1,  ADD4, 32'h0);
    vt[2]  = mkv(Z,    Z,     0, 0, 1, 1,  1, 4,  1, 0, 0, Z,     Z,    32'h12);
    vt[3]  = mkv(ADD1, SUB7,  1, 0, 0, 0,  0, 0,  1, 0, 0, Z,     Z,    32'h0);
    vt[4]  = mkv(Z,    Z,     0, 0, 0, 0,  0, 0,  0, 1, 0, ADD1,  Z,    32'h0);
    vt[5]  = mkv(Z,    Z,     0, 0, 1, 1,  0, 0,  0, 0, 0, Z,     Z,    32'h2);
    vt[6]  = mkv(LD9,  SD10,  1, 0, 0, 0,  0, 0,  1, 1, 0, SUB7,  Z,    32'h0);
    vt[7]  = mkv(Z,    Z,     0, 0, 0, 0,  0, 0,  0, 1, 0, LD9,   Z,    32'h80);
    vt[8]  = mkv(BEQ,  ADD15, 1, 0, 0, 0,  0, 0,  1, 1, 0, SD10,  Z,    32'h280);
    vt[9]  = mkv(Z,    Z,     0, 0, 0, 0,  0, 0,  0, 1, 0, BEQ,   Z,    32'h280);
    vt[10] = mkv(ADD1, ADD4,  1, 1, 0, 0,  0, 0,  0, 0, 0, Z,     Z,    32'h280);
    vt[11] = mkv(Z,    Z,     0, 0, 1, 7,  1, 9,  1, 0, 0, Z,     Z,    32'h280);
    vt[12] = mkv(ADD5, Z,     1, 0, 0, 0,  0, 0,  1, 0, 0, Z,     Z,    32'h0);
    vt[13] = mkv(Z,    Z,     0, 0, 1, 5,  0, 0,  1, 1, 0, ADD5,  Z,    32'h0);
    vt[14] = mkv(Z,    ADD4,  1, 0, 0, 0,  0, 0,  1, 0, 0, Z,     Z,    32'h20);
    vt[15] = mkv(Z,    Z,     0, 0, 1, 5,  0, 0,  0, 0, 0, Z,     Z,    32'h20);
    vt[16] = mkv(Z,    Z,     0, 0, 0, 0,  0, 0,  1, 1, 0, ADD4,  Z,    32'h0);
    vt[17] = mkv(Z,    Z,     0, 0, 0, 0,  1, 4,  1, 0, 0, Z,     Z,    32'h10);
    vt[18] = mkv(ADD1, ADD1B, 1, 0, 0, 0,  0, 0,  1, 0, 0, Z,     Z,    32'h0);
    vt[19] = mkv(Z,    Z,     0, 0, 0, 0,  0, 0,  0, 1, 0, ADD1,  Z,    32'h0);
    vt[20] = mkv(Z,    Z,     0, 0, 1, 1,  0, 0,  0, 0, 0, Z,     Z,    32'h2);
    vt[21] = mkv(Z,    Z,     1, 0, 0, 0,  0, 0,  1, 1, 0, ADD1B, Z,    32'h0);
    vt[22] = mkv(Z,    Z,     0, 0, 1, 1,  0, 0,  1, 0, 0, Z,     Z,    32'h2);
    vt[23] = mkv(Z,    Z,     0, 0, 1, 0,  0, 0,  1, 0, 0, Z,     Z,    32'h0);

    // Reset: outputs quiet while rst_n is low.
    rst_n = 1'b0;
    drive(Z, Z, 0, 0, 0, 0, 0, 0);
    step();
    #2;
    check("rst_ready", 0, 32'(in_ready), 32'd0);
    check("rst_v0",    0, 32'(iss0_valid), 32'd0);
    check("rst_v1",    0, 32'(iss1_valid), 32'd0);
    step();
    rst_n = 1'b1;

    // Cycle-by-cycle vector table.
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].i0, vt[i].i1, vt[i].iv, vt[i].fl,
            vt[i].w0e, vt[i].w0r, vt[i].w1e, vt[i].w1r);
      #2;
      check("in_ready", i, 32'(in_ready),   32'(vt[i].rdy));
      check("v0",       i, 32'(iss0_valid), 32'(vt[i].ev0));
      check("v1",       i, 32'(iss1_valid), 32'(vt[i].ev1));
      check("iss0",     i, 32'(iss0),       32'(vt[i].e0));
      check("iss1",     i, 32'(iss1),       32'(vt[i].e1));
      check("busy",     i, dut.u_sb.busy_q, vt[i].eb);
      step();
    end

    // Reset while a ready pair is held: nothing issues, state and scoreboard clear.
    drive(ADD1, ADD4, 1, 0, 0, 0, 0, 0);
    #2;
    check("mid_acc_ready", 0, 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b0;
    drive(Z, Z, 0, 0, 0, 0, 0, 0);
    #2;
    check("mid_rst_ready", 0, 32'(in_ready),   32'd0);
    check("mid_rst_v0",    0, 32'(iss0_valid), 32'd0);
    check("mid_rst_v1",    0, 32'(iss1_valid), 32'd0);
    step();
    rst_n = 1'b1;
    #2;
    check("post_rst_ready", 0, 32'(in_ready),   32'd1);
    check("post_rst_v0",    0, 32'(iss0_valid), 32'd0);
    check("post_rst_busy",  0, dut.u_sb.busy_q, 32'd0);
    step();

`ifdef SCHED_PERF_EN
    // Three dual cycles, two single cycles, four stall cycles.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(NW0, NW1, 1, 0, 0, 0, 0, 0); step();
    drive(NW0, NW1, 1, 0, 0, 0, 0, 0); step();
    drive(NW0, NW1, 1, 0, 0, 0, 0, 0); step();
    drive(W20, Z,   1, 0, 0, 0, 0, 0); step();
    drive(R21, Z,   1, 0, 0, 0, 0, 0); step();
    drive(Z,   Z,   0, 0, 0, 0, 0, 0); step(); step(); step();
    drive(Z,   Z,   0, 0, 1, 20, 0, 0); step();
    drive(Z,   Z,   0, 0, 0, 0, 0, 0); step();
    #2;
    check("perf_dual",   0, perf_dual,   32'd3);
    check("perf_single", 0, perf_single, 32'd2);
    check("perf_stall",  0, perf_stall,  32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
